xalu_ctrl: RTL

XALU_CTRL -- requirements
Module: xalu_ctrl

---
 rtl/xalu_defs.sv | 47 ++++
 rtl/xalu_ctrl_if.sv | 17 +
 rtl/xalu_cnt.sv | 26 ++
 rtl/xalu_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/xalu_defs.sv
// Shared op encodings, latencies and arithmetic helpers for the mult/div unit.
// Codes 7-10 (madd family) are only decoded when XALU_MADD_EN is defined.
package xalu_defs;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} xalu_state_e;

  // Low 64 bits of the product of 64-bit extended operands is the exact product.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Magnitude divide then fix signs: avoids the -2^31 / -1 signed overflow case.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_rem(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? (~a + 32'd1) : a;
    mb = nb ? (~b + 32'd1) : b;
    q  = (mb == '0) ? '0 : ma / mb;
    r  = (mb == '0) ? '0 : ma % mb;
    if (na ^ nb) q = ~q + 32'd1;
    if (na)      r = ~r + 32'd1;
    return {r, q};
  endfunction
endpackage

// File: rtl/xalu_ctrl_if.sv
// E-stage <-> mult/div unit bus: launch strobe, operands, kill, and HI/LO/stall back.
interface xalu_ctrl_if;
  logic        Start;
  logic [3:0]  XALUOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Flush;
  logic        Busy;
  logic        StallX;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, XALUOp, D1, D2, Flush,
                  input  Busy, StallX, HI, LO);
  modport slave  (input  Start, XALUOp, D1, D2, Flush,
                  output Busy, StallX, HI, LO);
endinterface

// File: rtl/xalu_cnt.sv
// Loadable down-counter with one/zero flags, used to time mult/div latency.
import xalu_defs::*;

module xalu_cnt #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         one,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (load)    cnt <= load_val;
    else if (dec)     cnt <= cnt - 1'b1;
  end

  assign one  = (cnt == W'(1));
  assign zero = (cnt == '0);
endmodule

// File: rtl/xalu_ctrl.sv
// Multi-cycle mult/div controller owning HI/LO; result computed at launch, committed at count 1.
// Define XALU_MADD_EN to enable madd/maddu/msub/msubu (codes 7-10).
import xalu_defs::*;

module xalu_ctrl (
  input  logic  clk,
  input  logic  reset,
  xalu_ctrl_if.slave bus
);
  xalu_state_e state;
  logic        busy, wr_en, cnt_one, cnt_zero;
  logic        is_mul, is_div, sgn, idle_go;
  logic [31:0] hi, lo, res_hi, res_lo;
  logic [63:0] prod, mul_res, div_res;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    case (bus.XALUOp)
      OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef XALU_MADD_EN
      OP_MADD, OP_MSUB:   begin is_mul = 1'b1; sgn = 1'b1; end
      OP_MADDU, OP_MSUBU: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign prod    = mul64(bus.D1, bus.D2, sgn);
  assign div_res = div_rem(bus.D1, bus.D2, sgn);

  always_comb begin
    mul_res = prod;
`ifdef XALU_MADD_EN
    if (bus.XALUOp == OP_MADD || bus.XALUOp == OP_MADDU)      mul_res = {hi, lo} + prod;
    else if (bus.XALUOp == OP_MSUB || bus.XALUOp == OP_MSUBU) mul_res = {hi, lo} - prod;
`endif
  end

  assign idle_go = bus.Start && !bus.Flush && (state == S_IDLE);

  xalu_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.Flush),
    .load     (idle_go && (is_mul || is_div)),
    .load_val (is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES)),
    .dec      (busy && !cnt_zero),
    .one      (cnt_one),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      wr_en  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (bus.Flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.Start) begin
          if (is_mul) begin
            state            <= S_MUL;
            busy             <= 1'b1;
            wr_en            <= 1'b1;
            {res_hi, res_lo} <= mul_res;
          end else if (is_div) begin
            // Divide by zero still runs the full latency but never commits.
            state            <= S_DIV;
            busy             <= 1'b1;
            wr_en            <= (bus.D2 != '0);
            {res_hi, res_lo} <= div_res;
          end else if (bus.XALUOp == OP_MTHI) begin
            hi <= bus.D1;
          end else if (bus.XALUOp == OP_MTLO) begin
            lo <= bus.D1;
          end
        end
        S_MUL, S_DIV: if (cnt_one) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (wr_en) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.StallX = bus.Start | busy;
  assign bus.HI     = hi;
  assign bus.LO     = lo;
endmodule
